// File: rtl/hilo_unit_pkg.sv
// rtl/hilo_unit_pkg.sv - shared types and constants for the HI/LO register unit
package hilo_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_MUL_BUSY = 2'd2
    } state_t;

    localparam logic OP_SIGNED   = 1'b1;
    localparam logic OP_UNSIGNED = 1'b0;

    localparam int DIV_CYCLES_DEFAULT = 4;
    localparam int MUL_CYCLES_DEFAULT = 2;

    // The counter must be able to hold the larger of the two hold times.
    function automatic int cnt_width(input int div_cycles, input int mul_cycles);
        int m;
        m = (div_cycles > mul_cycles) ? div_cycles : mul_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - pipeline, divider and multiplier signals of the HI/LO unit
interface hilo_unit_if;
    logic        div_start;
    logic        mul_start;
    logic        op_sign;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        hilo_read;
    logic        div_ena;
    logic        div_sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        div_zero;

    modport master (
        output div_start, mul_start, op_sign, rs_data, rt_data,
        output mthi, mtlo, hilo_read, div_q, div_r, mul_hi, mul_lo,
        input  div_ena, div_sign, op_a, op_b, hi, lo, busy, stall, div_zero
    );

    modport slave (
        input  div_start, mul_start, op_sign, rs_data, rt_data,
        input  mthi, mtlo, hilo_read, div_q, div_r, mul_hi, mul_lo,
        output div_ena, div_sign, op_a, op_b, hi, lo, busy, stall, div_zero
    );
endinterface

// File: rtl/hilo_regfile.sv
// rtl/hilo_regfile.sv - HI/LO register pair; a result commit outranks mthi/mtlo
module hilo_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [31:0] commit_hi,
    input  logic [31:0] commit_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - EX-stage HI/LO unit: operand hold, result commit and stall generation
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    hilo_unit_if.slave bus
);

    localparam int CNT_W = cnt_width(DIV_CYCLES, MUL_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             latch;
    logic             commit;
    logic             zero_d;
    logic             zero_q;
    logic             sign_q;
    logic [31:0]      op_a_q, op_b_q;
    logic             idle;
    logic             mt_ok;

    assign idle  = (state_q == ST_IDLE);
    // A start in the same cycle wins over mthi/mtlo.
    assign mt_ok = idle & ~bus.div_start & ~bus.mul_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        zero_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.div_start) begin
                    if (bus.rt_data == 32'd0) begin
                        zero_d = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        state_d = ST_DIV_BUSY;
                    end
                end else if (bus.mul_start) begin
                    latch   = 1'b1;
                    cnt_d   = CNT_W'(MUL_CYCLES);
                    state_d = ST_MUL_BUSY;
                end
            end
            ST_DIV_BUSY, ST_MUL_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands stay frozen for the whole busy window so the datapath output settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q <= '0;
            op_b_q <= '0;
            sign_q <= OP_UNSIGNED;
        end else if (latch) begin
            op_a_q <= bus.rs_data;
            op_b_q <= bus.rt_data;
            sign_q <= bus.op_sign;
        end
    end

    hilo_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .commit_hi ((state_q == ST_DIV_BUSY) ? bus.div_r : bus.mul_hi),
        .commit_lo ((state_q == ST_DIV_BUSY) ? bus.div_q : bus.mul_lo),
        .wr_hi     (mt_ok & bus.mthi),
        .wr_lo     (mt_ok & bus.mtlo),
        .wr_data   (bus.rs_data),
        .hi        (bus.hi),
        .lo        (bus.lo)
    );

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.div_sign = sign_q;
    assign bus.div_ena  = (state_q == ST_DIV_BUSY);
    assign bus.busy     = ~idle;
    assign bus.div_zero = zero_q;
    assign bus.stall    = ~idle & (bus.div_start | bus.mul_start | bus.mthi |
                                   bus.mtlo | bus.hilo_read);

endmodule
